// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: batch sequencer sharing one RegFile port
// and a registered ALU: fetch, execute, write back per op.
module alu_seq_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 20,
  parameter int RES_W   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              abort,
  output logic              rf_rd_en,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_fun,
  input  logic [RES_W-1:0]  alu_out,
  output logic              mux_sel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   ops_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RDW, S_EXEC, S_WR, S_DONE
  } state_t;

  localparam int LW =
    (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W:0]   r_ops;
  logic [LW-1:0]     r_lat;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [3:0]        r_fun;
  logic              w_accept;
  logic              w_lat_end;
  logic              w_last;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_lat_end = (r_lat == LW'(ALU_LAT - 1));
  assign w_last    = (r_rem == (ADDR_W+1)'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and Moore-decoded strobes
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    rf_rd_en   = 1'b0;
    rf_wr_en   = 1'b0;
    rf_addr    = '0;
    rf_wr_data = '0;
    mux_sel    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid)
          w_next = (cmd_count == '0) ? S_DONE : S_RD;
      end
      S_RD: begin
        rf_rd_en = 1'b1;
        rf_addr  = r_src;
        w_next   = S_RDW;
      end
      S_RDW: w_next = S_EXEC;
      S_EXEC: begin
        mux_sel = 1'b1;
        if (w_lat_end) w_next = S_WR;
      end
      S_WR: begin
        rf_wr_en   = 1'b1;
        rf_addr    = r_dst;
        rf_wr_data = {{(DATA_W-RES_W){1'b0}}, alu_out};
        mux_sel    = 1'b1;
        w_next     = w_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  // Job pointers, operand latch and ALU latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
      r_ops <= '0;
      r_lat <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_fun <= '0;
    end else begin
      if (w_accept) begin
        r_src <= cmd_src;
        r_dst <= cmd_dst;
        r_rem <= cmd_count;
        r_ops <= '0;
      end
      if (r_state == S_RDW) begin
        r_fun <= rf_rd_data[19:16];
        r_b   <= rf_rd_data[15:8];
        r_a   <= rf_rd_data[7:0];
      end
      if (r_state == S_EXEC) r_lat <= r_lat + 1'b1;
      else                   r_lat <= '0;
      if (r_state == S_WR) begin
        r_src <= r_src + 1'b1;
        r_dst <= r_dst + 1'b1;
        r_rem <= r_rem - 1'b1;
        r_ops <= r_ops + 1'b1;
      end
    end
  end

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_fun  = r_fun;
  assign ops_done = r_ops;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench with RegFile and
// registered ALU models around alu_seq_ctrl.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [4:0]  cmd_count;
  logic        abort;
  logic        rf_rd_en;
  logic        rf_wr_en;
  logic [3:0]  rf_addr;
  logic [19:0] rf_wr_data;
  logic [19:0] rf_rd_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        mux_sel;
  logic        busy;
  logic        done;
  logic [4:0]  ops_done;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_count(cmd_count), .abort(abort),
    .rf_rd_en(rf_rd_en), .rf_wr_en(rf_wr_en),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .mux_sel(mux_sel),
    .busy(busy), .done(done), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  logic [19:0] mem [16];
  int cyc = 0;
  int acc = 0;
  int checks = 0;
  int errors = 0;
  int clash = 0;
  int done_cnt = 0;
  int rd_rel[$];
  int rd_adr[$];
  int wr_rel[$];
  int wr_adr[$];

  function automatic logic [15:0] alu_f(
    input logic [3:0] f, input logic [7:0] a,
    input logic [7:0] b);
    logic [15:0] xa, xb;
    xa = {8'h00, a};
    xb = {8'h00, b};
    case (f)
      4'd0: return xa + xb;
      4'd1: return xa - xb;
      4'd2: return xa & xb;
      4'd3: return xa | xb;
      4'd4: return xa ^ xb;
      4'd5: return xa * xb;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    alu_out <= alu_f(alu_fun, alu_a, alu_b);
    if (rf_rd_en) rf_rd_data <= mem[rf_addr];
    if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
  end

  always @(negedge clk) begin
    if (rf_rd_en) begin
      rd_rel.push_back(cyc - acc);
      rd_adr.push_back(int'(rf_addr));
    end
    if (rf_wr_en) begin
      wr_rel.push_back(cyc - acc);
      wr_adr.push_back(int'(rf_addr));
    end
    if (rf_rd_en && rf_wr_en) clash++;
    if (done) done_cnt++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr_logs();
    rd_rel.delete(); rd_adr.delete();
    wr_rel.delete(); wr_adr.delete();
  endtask

  task automatic start_job(input logic [3:0] s,
                           input logic [3:0] d,
                           input logic [4:0] n,
                           input bit hold);
    @(negedge clk);
    cmd_src   = s;
    cmd_dst   = d;
    cmd_count = n;
    cmd_valid = 1'b1;
    acc = cyc;
    clr_logs();
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic goto(input int rel);
    do @(negedge clk); while (cyc - acc < rel);
  endtask

  task automatic wait_done(input string nm,
                           input int exp_rel);
    bit seen;
    int rel;
    seen = 0;
    rel = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        rel = cyc - acc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got none expected %0d",
               nm, exp_rel);
    end else begin
      chk({nm, "_done_cyc"}, 32'(rel), 32'(exp_rel));
    end
  endtask

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [3:0]  fun;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{4'd2,  4'd5,  4'd0, 8'h04, 8'h03, 16'h0007};
    vt[1] = '{4'd1,  4'd6,  4'd1, 8'h20, 8'h05, 16'h001B};
    vt[2] = '{4'd3,  4'd3,  4'd1, 8'h03, 8'h05, 16'hFFFE};
    vt[3] = '{4'd4,  4'd7,  4'd2, 8'hF0, 8'h3C, 16'h0030};
    vt[4] = '{4'd6,  4'd9,  4'd3, 8'hF0, 8'h0F, 16'h00FF};
    vt[5] = '{4'd7,  4'd11, 4'd4, 8'hAA, 8'hFF, 16'h0055};
    vt[6] = '{4'd12, 4'd13, 4'd5, 8'hFF, 8'hFF, 16'hFE01};
    vt[7] = '{4'd14, 4'd1,  4'd0, 8'hFF, 8'h01, 16'h0100};

    for (int i = 0; i < 16; i++) mem[i] = 20'h0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_count = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes",
        {29'd0, rf_rd_en, rf_wr_en, mux_sel}, 32'd0);
    chk("rst_alu", {12'd0, alu_fun, alu_b, alu_a},
        32'd0);
    chk("rst_ops", 32'(ops_done), 32'd0);
    rst = 1'b0;

    // single-op jobs
    for (int i = 0; i < 8; i++) begin
      mem[vt[i].src] = {vt[i].fun, vt[i].b, vt[i].a};
      start_job(vt[i].src, vt[i].dst, 5'd1, 0);
      wait_done($sformatf("v%0d", i), 5);
      chk($sformatf("v%0d_busy_done", i),
          32'(busy), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_result", i),
          32'(mem[vt[i].dst]), {16'd0, vt[i].exp});
      chk($sformatf("v%0d_ops", i),
          32'(ops_done), 32'd1);
      chk($sformatf("v%0d_rd", i),
          {32'(rd_rel.size()), rd_rel[0], rd_adr[0]},
          {32'd1, 32'd1, 32'(vt[i].src)});
      chk($sformatf("v%0d_wr", i),
          {32'(wr_rel.size()), wr_rel[0], wr_adr[0]},
          {32'd1, 32'd4, 32'(vt[i].dst)});
    end

    // 3-op job, 4-cycle spacing
    mem[0] = {4'h0, 8'h01, 8'h02};
    mem[1] = {4'h1, 8'h01, 8'h09};
    mem[2] = {4'h4, 8'h0F, 8'h33};
    start_job(4'd0, 4'd8, 5'd3, 0);
    wait_done("n3", 13);
    @(negedge clk);
    chk("n3_ops", 32'(ops_done), 32'd3);
    chk("n3_rd_n", 32'(rd_rel.size()), 32'd3);
    chk("n3_wr_n", 32'(wr_rel.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n3_rd%0d", k),
          {rd_rel[k], rd_adr[k]},
          {32'(1 + 4*k), 32'(k)});
      chk($sformatf("n3_wr%0d", k),
          {wr_rel[k], wr_adr[k]},
          {32'(4 + 4*k), 32'(8 + k)});
    end
    chk("n3_m8", 32'(mem[8]), 32'h0003);
    chk("n3_m9", 32'(mem[9]), 32'h0008);
    chk("n3_m10", 32'(mem[10]), 32'h003C);

    // zero-length job
    start_job(4'd3, 4'd4, 5'd0, 0);
    wait_done("n0", 1);
    chk("n0_ready_done", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("n0_ready_back", 32'(cmd_ready), 32'd1);
    chk("n0_no_access",
        32'(rd_rel.size() + wr_rel.size()), 32'd0);

    // wrap at top of address space
    mem[15] = {4'h0, 8'h02, 8'h01};
    mem[0]  = {4'h3, 8'h0F, 8'hF0};
    start_job(4'd15, 4'd15, 5'd2, 0);
    wait_done("wrap", 9);
    @(negedge clk);
    chk("wrap_rd",
        {rd_rel[0], rd_adr[0], rd_rel[1], rd_adr[1]},
        {32'd1, 32'd15, 32'd5, 32'd0});
    chk("wrap_wr",
        {wr_rel[0], wr_adr[0], wr_rel[1], wr_adr[1]},
        {32'd4, 32'd15, 32'd8, 32'd0});
    chk("wrap_m15", 32'(mem[15]), 32'h0003);
    chk("wrap_m0", 32'(mem[0]), 32'h00FF);

    // abort in second EXEC of a 4-op job
    for (int k = 0; k < 4; k++)
      mem[k] = {4'h0, 8'h01, 8'(k)};
    start_job(4'd0, 4'd8, 5'd4, 0);
    begin
      int dc;
      dc = done_cnt;
      goto(7);
      chk("ab_in_exec", 32'(mux_sel), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("ab_idle", {30'd0, busy, cmd_ready}, 32'd1);
      chk("ab_ops", 32'(ops_done), 32'd1);
      repeat (20) @(negedge clk);
      chk("ab_no_done", 32'(done_cnt - dc), 32'd0);
      chk("ab_wr_n", 32'(wr_rel.size()), 32'd1);
    end

    // cmd_valid held high while busy
    mem[5] = {4'h0, 8'h10, 8'h01};
    start_job(4'd5, 4'd6, 5'd1, 1);
    for (int r = 1; r <= 5; r++) begin
      goto(r);
      chk($sformatf("hold_ready%0d", r),
          32'(cmd_ready), 32'd0);
    end
    goto(6);
    chk("hold_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done("hold", 11);
    chk("hold_rd",
        {32'(rd_rel.size()), rd_rel[0], rd_rel[1]},
        {32'd2, 32'd1, 32'd7});

    // reset in RDW
    mem[2] = {4'h5, 8'h07, 8'h09};
    start_job(4'd2, 4'd3, 5'd2, 0);
    goto(2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdw_out",
        {busy, done, rf_rd_en, rf_wr_en, mux_sel,
         ops_done, alu_fun, alu_b, alu_a, 3'd0},
        {1'b0, 4'd0, 5'd0, 4'd0, 16'd0, 3'd0});
    chk("rst_rdw_addr",
        {12'd0, rf_addr, rf_wr_data}, 32'd0);
    chk("rst_rdw_ready", 32'(cmd_ready), 32'd1);
    repeat (10) @(negedge clk);
    chk("rst_rdw_no_wr", 32'(wr_rel.size()), 32'd0);

    chk("no_rd_wr_clash", 32'(clash), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
